clint_mmap: RTL and testbench
=============================

CLINT_MMAP -- requirements
Module: clint_mmap

Interface
REQ-001 SHALL have parameter HARTS, default 1, number of harts, each with its own mtimecmp and msip (1..16).
REQ-002 SHALL have parameter DIV_W, default 8, width of the timebase prescaler divisor.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-005 SHALL have port re, input, 1, read strobe.
REQ-006 SHALL have port we, input, 1, write strobe.
REQ-007 SHALL have port addr, input, [31:2], word address; only addr[9:2] decoded, upper bits ignored.
REQ-008 SHALL have port wd, input, 32, write data; full-word writes only.
REQ-009 SHALL have port rd, output, 32, registered read data.
REQ-010 SHALL have port mtime, output, 64, current timer value.
REQ-011 SHALL have port mtip, output, HARTS, per-hart timer interrupt pending.
REQ-012 SHALL have port msip, output, HARTS, per-hart software interrupt pending.

Function
REQ-013 Register map (byte offset): 0x000 mtime[31:0]; 0x004 mtime[63:32]; 0x008 CTRL (bit0 EN, bits[8+DIV_W-1:8] DIV); 0x00C MSIP (bits[HARTS-1:0]); 0x100+8h mtimecmp[h][31:0]; 0x104+8h mtimecmp[h][63:32].
REQ-014 Read latency SHALL be 1 cycle: rd holds the addressed value sampled in the cycle re=1; rd holds its previous value when re=0.
REQ-015 Unmapped offsets, and mtimecmp/MSIP bits for hart >= HARTS, SHALL read 0 and ignore writes; CTRL/MSIP unused bits read 0.
REQ-016 re and we in the same cycle to the same offset: the write is performed; rd returns the pre-write value.
REQ-017 Prescaler counter SHALL count 0..DIV while EN=1; mtime increments by 1 in the cycle the counter equals DIV, and the counter returns to 0 the same cycle; DIV=0 gives increment every cycle.
REQ-018 EN=0 SHALL freeze mtime and the prescaler counter at their current values.
REQ-019 mtime SHALL wrap from 2^64-1 to 0 with no other side effect.
REQ-020 A write to either mtime half SHALL replace that half only, suppress the increment in that cycle, and clear the prescaler counter.
REQ-021 A write to CTRL SHALL clear the prescaler counter; the new DIV applies from the next cycle.
REQ-022 mtip[h] SHALL be registered: equals (mtime >= mtimecmp[h]), unsigned 64-bit, evaluated on the previous cycle's values (1-cycle lag).
REQ-023 mtip[h] SHALL deassert only via mtimecmp[h] or mtime writes; no clear-on-read.
REQ-024 msip SHALL equal the MSIP register directly.

Reset
REQ-025 While reset=0 at a clock edge: mtime=0, prescaler=0, EN=1, DIV=0, MSIP=0, all mtimecmp=2^64-1, rd=0, mtip=0; re/we ignored.
REQ-026 Reset asserted mid-operation SHALL take effect on that edge regardless of re/we; first access honoured is in the cycle after reset returns to 1.

Configuration
REQ-027 Macro CLINT_MMAP_SNAPSHOT_EN defined: a read of 0x000 SHALL also latch mtime[63:32] into a shadow register; reads of 0x004 return the shadow, giving a tear-free 64-bit read; shadow resets to 0.
REQ-028 Macro CLINT_MMAP_SNAPSHOT_EN undefined: reads of 0x004 SHALL return live mtime[63:32]; no shadow register exists.

Verification
REQ-029 Release reset, DIV=0, EN=1 -> mtime reads 10 at 10 cycles after reset; mtip=0, msip=0, rd=0 during reset.
REQ-030 Write CTRL=0x0301 (DIV=3) -> mtime increments exactly once every 4 cycles; write CTRL=0 -> mtime frozen for 20 cycles.
REQ-031 HARTS=2, mtimecmp[1]=50, mtimecmp[0]=2^64-1 -> mtip=2'b10 one cycle after mtime reaches 50; write mtimecmp[1] hi=1 -> mtip[1] clears next cycle.
REQ-032 Write mtime={0xFFFFFFFF,0xFFFFFFFE} -> two increments later mtime=0; mtip for mtimecmp=0 stays 1 across wrap.
REQ-033 With CLINT_MMAP_SNAPSHOT_EN, mtime lo=0xFFFFFFFF: read 0x000 then 0x004 after carry -> hi returns pre-carry value; without macro -> hi returns incremented value.
REQ-034 Write MSIP=0x3 with HARTS=1 -> msip=1'b1, read MSIP returns 0x1; read offset 0x010 -> 0; reset mid-write -> all registers at reset values.

Source files
------------

// File: rtl/clint_mmap.sv
// ============================================================================
//  clint_mmap : memory-mapped core-local interruptor with a prescaled 64-bit
//  mtime and per-hart mtimecmp/msip. Option: CLINT_MMAP_SNAPSHOT_EN (tear-free hi read).
//  Revision  : 1.0
// ============================================================================
`default_nettype none

module clint_mmap #(
  parameter int HARTS = 1,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             re,
  input  logic             we,
  input  logic [31:2]      addr,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  output logic [63:0]      mtime,
  output logic [HARTS-1:0] mtip,
  output logic [HARTS-1:0] msip
);

  localparam logic [7:0] C_MTIME_LO = 8'h00;
  localparam logic [7:0] C_MTIME_HI = 8'h01;
  localparam logic [7:0] C_CTRL     = 8'h02;
  localparam logic [7:0] C_MSIP     = 8'h03;
  localparam int         C_CMP_BASE = 64;

  logic [7:0]       w_word;
  logic             w_addr_unused;
  logic             w_wr_lo, w_wr_hi, w_wr_ctrl, w_wr_msip;
  logic [31:0]      w_rdata;
  logic [31:0]      w_ctrl;

  logic [63:0]      mtime_q, mtime_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic             en_q;
  logic [DIV_W-1:0] div_q;
  logic [HARTS-1:0] msip_q;
  logic [HARTS-1:0] mtip_q;
  logic [31:0]      rd_q;
  logic [63:0]      cmp_q [HARTS];

  assign w_word        = addr[9:2];
  assign w_addr_unused = ^addr[31:10];

  assign w_wr_lo   = we && (w_word == C_MTIME_LO);
  assign w_wr_hi   = we && (w_word == C_MTIME_HI);
  assign w_wr_ctrl = we && (w_word == C_CTRL);
  assign w_wr_msip = we && (w_word == C_MSIP);

  always_comb begin
    w_ctrl              = '0;
    w_ctrl[0]           = en_q;
    w_ctrl[8 +: DIV_W]  = div_q;
  end

  // A write to either half wins over the prescaled increment in that cycle.
  always_comb begin
    mtime_d = mtime_q;
    pre_d   = pre_q;
    if (en_q) begin
      if (pre_q == div_q) begin
        mtime_d = mtime_q + 64'd1;
        pre_d   = '0;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    if (w_wr_lo) begin
      mtime_d = {mtime_q[63:32], wd};
      pre_d   = '0;
    end
    if (w_wr_hi) begin
      mtime_d = {wd, mtime_q[31:0]};
      pre_d   = '0;
    end
    if (w_wr_ctrl) begin
      pre_d = '0;
    end
  end

`ifdef CLINT_MMAP_SNAPSHOT_EN
  logic [31:0] shadow_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_q <= '0;
    end else if (re && (w_word == C_MTIME_LO)) begin
      shadow_q <= mtime_q[63:32];
    end
  end
`endif

  always_comb begin
    w_rdata = '0;
    case (w_word)
      C_MTIME_LO: w_rdata = mtime_q[31:0];
`ifdef CLINT_MMAP_SNAPSHOT_EN
      C_MTIME_HI: w_rdata = shadow_q;
`else
      C_MTIME_HI: w_rdata = mtime_q[63:32];
`endif
      C_CTRL:     w_rdata = w_ctrl;
      C_MSIP:     w_rdata[HARTS-1:0] = msip_q;
      default:    ;
    endcase
    for (int h = 0; h < HARTS; h++) begin
      if (w_word == 8'(C_CMP_BASE + 2 * h)) w_rdata = cmp_q[h][31:0];
      if (w_word == 8'(C_CMP_BASE + 2 * h + 1)) w_rdata = cmp_q[h][63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mtime_q <= '0;
      pre_q   <= '0;
      en_q    <= 1'b1;
      div_q   <= '0;
      msip_q  <= '0;
      rd_q    <= '0;
    end else begin
      mtime_q <= mtime_d;
      pre_q   <= pre_d;
      if (w_wr_ctrl) begin
        en_q  <= wd[0];
        div_q <= wd[8 +: DIV_W];
      end
      if (w_wr_msip) begin
        msip_q <= wd[HARTS-1:0];
      end
      if (re) begin
        rd_q <= w_rdata;
      end
    end
  end

  // mtip compares the values held before this edge, hence its one-cycle lag.
  always_ff @(posedge clk) begin
    for (int h = 0; h < HARTS; h++) begin
      if (!reset) begin
        cmp_q[h]  <= '1;
        mtip_q[h] <= 1'b0;
      end else begin
        if (we && (w_word == 8'(C_CMP_BASE + 2 * h))) cmp_q[h][31:0] <= wd;
        if (we && (w_word == 8'(C_CMP_BASE + 2 * h + 1))) cmp_q[h][63:32] <= wd;
        mtip_q[h] <= (mtime_q >= cmp_q[h]);
      end
    end
  end

  assign rd    = rd_q;
  assign mtime = mtime_q;
  assign mtip  = mtip_q;
  assign msip  = msip_q;

endmodule

`default_nettype wire

// File: tb/tb_clint_mmap.sv
// ============================================================================
//  tb_clint_mmap : directed self-checking bench for clint_mmap (HARTS=2).
//  Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_clint_mmap;

  logic        clk;
  logic        reset;
  logic        re;
  logic        we;
  logic [31:2] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [63:0] mtime;
  logic [1:0]  mtip;
  logic [1:0]  msip;

  int total;
  int bad;

  clint_mmap #(.HARTS(2), .DIV_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .re    (re),
    .we    (we),
    .addr  (addr),
    .wd    (wd),
    .rd    (rd),
    .mtime (mtime),
    .mtip  (mtip),
    .msip  (msip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we   = 1'b1;
    addr = a[31:2];
    wd   = d;
    step(1);
    we   = 1'b0;
  endtask

  task automatic rdreg(input logic [31:0] a);
    re   = 1'b1;
    addr = a[31:2];
    step(1);
    re   = 1'b0;
  endtask

  initial begin
    logic [31:0] hi_exp;
    total = 0;
    bad   = 0;
    // Reset with accesses attempted; they must be ignored.
    reset = 1'b0;
    re    = 1'b1;
    we    = 1'b1;
    addr  = 30'h3;
    wd    = 32'h3;
    step(3);
    check("rst_mtime", mtime, 64'd0);
    check("rst_mtip", {62'd0, mtip}, 64'd0);
    check("rst_msip", {62'd0, msip}, 64'd0);
    check("rst_rd", {32'd0, rd}, 64'd0);
    reset = 1'b1;
    re    = 1'b0;
    we    = 1'b0;

    step(10);
    check("mtime_10", mtime, 64'd10);
    check("mtip_idle", {62'd0, mtip}, 64'd0);
    rdreg(32'h000);
    check("rd_mtime_lo", {32'd0, rd}, 64'd10);
    check("mtime_11", mtime, 64'd11);

    // DIV=3: one increment per 4 cycles.
    wr(32'h008, 32'h0000_0301);
    check("div3_start", mtime, 64'd12);
    step(3);
    check("div3_hold", mtime, 64'd12);
    step(1);
    check("div3_inc1", mtime, 64'd13);
    step(4);
    check("div3_inc2", mtime, 64'd14);
    rdreg(32'h008);
    check("rd_ctrl", {32'd0, rd}, 64'h301);
    wr(32'h008, 32'h0);
    check("frozen_0", mtime, 64'd14);
    step(20);
    check("frozen_20", mtime, 64'd14);
    check("rd_hold", {32'd0, rd}, 64'h301);

    // mtimecmp[1]=50, mtimecmp[0] stays all-ones.
    wr(32'h108, 32'd50);
    wr(32'h10C, 32'd0);
    wr(32'h000, 32'd45);
    wr(32'h008, 32'h1);
    check("mtime_45", mtime, 64'd45);
    step(5);
    check("mtime_50", mtime, 64'd50);
    check("mtip_lag", {62'd0, mtip}, 64'd0);
    step(1);
    check("mtip_set", {62'd0, mtip}, 64'h2);
    wr(32'h10C, 32'd1);
    check("mtip_still", {62'd0, mtip}, 64'h2);
    step(1);
    check("mtip_clr", {62'd0, mtip}, 64'd0);

    // Wrap with mtimecmp[0]=0.
    wr(32'h100, 32'd0);
    wr(32'h104, 32'd0);
    wr(32'h000, 32'hFFFF_FFFE);
    wr(32'h004, 32'hFFFF_FFFF);
    check("wrap_set", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    check("mtip0_pre", {63'd0, mtip[0]}, 64'd1);
    step(1);
    check("wrap_max", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1);
    check("wrap_zero", mtime, 64'd0);
    check("mtip0_wrap", {63'd0, mtip[0]}, 64'd1);
    step(1);
    check("mtip0_after", {63'd0, mtip[0]}, 64'd1);
    check("wrap_one", mtime, 64'd1);

    // Hi read after a carry between lo and hi reads.
    wr(32'h004, 32'd5);
    wr(32'h000, 32'hFFFF_FFFF);
    check("snap_set", mtime, 64'h5_FFFF_FFFF);
    rdreg(32'h000);
    check("snap_lo", {32'd0, rd}, 64'hFFFF_FFFF);
    check("snap_carry", mtime, 64'h6_0000_0000);
    rdreg(32'h004);
`ifdef CLINT_MMAP_SNAPSHOT_EN
    hi_exp = 32'd5;
`else
    hi_exp = 32'd6;
`endif
    check("snap_hi", {32'd0, rd}, {32'd0, hi_exp});

    // MSIP, unmapped and out-of-range harts.
    wr(32'h00C, 32'h7);
    check("msip_w", {62'd0, msip}, 64'h3);
    rdreg(32'h00C);
    check("rd_msip", {32'd0, rd}, 64'h3);
    rdreg(32'h010);
    check("rd_unmapped", {32'd0, rd}, 64'd0);
    rdreg(32'h110);
    check("rd_hart2", {32'd0, rd}, 64'd0);
    rdreg(32'h10C);
    check("rd_cmp1_hi", {32'd0, rd}, 64'd1);
    rdreg(32'h108);
    check("rd_cmp1_lo", {32'd0, rd}, 64'd50);

    // Same-cycle read and write: old value returned, write applied.
    re   = 1'b1;
    we   = 1'b1;
    addr = 30'h3;
    wd   = 32'h0;
    step(1);
    re   = 1'b0;
    we   = 1'b0;
    check("rw_rd_old", {32'd0, rd}, 64'h3);
    check("rw_msip_new", {62'd0, msip}, 64'd0);

    // Reset during an access.
    wr(32'h00C, 32'h3);
    reset = 1'b0;
    re    = 1'b1;
    we    = 1'b1;
    addr  = 30'h3;
    wd    = 32'h3;
    step(1);
    check("mrst_mtime", mtime, 64'd0);
    check("mrst_msip", {62'd0, msip}, 64'd0);
    check("mrst_mtip", {62'd0, mtip}, 64'd0);
    check("mrst_rd", {32'd0, rd}, 64'd0);
    reset = 1'b1;
    re    = 1'b0;
    we    = 1'b0;
    rdreg(32'h008);
    check("mrst_ctrl", {32'd0, rd}, 64'h1);
    rdreg(32'h104);
    check("mrst_cmp0_hi", {32'd0, rd}, 64'hFFFF_FFFF);
    check("mrst_mtip2", {62'd0, mtip}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
